// File: rtl/calc_pkg.sv
// Shared encodings for the accumulator-bank calculator: opcodes, FSM states
// and the opcode field width.
package calc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_e;

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// The final partial sum is presented combinationally alongside valid.
module calc_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic             valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] psum;
  logic [2*WIDTH-1:0] psum_next;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  assign psum_next = psum + (mplier[0] ? mcand : '0);
  // valid marks the edge that consumes the last multiplier bit
  assign valid     = (cnt == CNT_W'(1));
  assign prod_lo   = psum_next[WIDTH-1:0];
  assign prod_hi   = psum_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      psum   <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      psum   <= '0;
      mplier <= b;
      cnt    <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      psum   <= psum_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/calc_acc_bank.sv
// Bank of NUM_ACC accumulators driven by an execute button; one op per press.
// Optional button debounce filter enabled by defining CALC_DEBOUNCE_EN.
//
// state   | meaning
// IDLE    | waiting for a press; operands captured on go
// EXEC    | single-cycle ALU op, writeback on the next edge
// MUL     | sequential multiply in progress, writeback on last bit
module calc_acc_bank
  import calc_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int NUM_ACC         = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       btnd,
  input  logic [OP_W-1:0]            op,
  input  logic [$clog2(NUM_ACC)-1:0] sel,
  input  logic [WIDTH-1:0]           sw,
  output logic [WIDTH-1:0]           led,
  output logic                       busy,
  output logic                       done,
  output logic                       zero,
  output logic                       ovf
);

  localparam int SEL_W = $clog2(NUM_ACC);
  localparam int SH_W  = $clog2(WIDTH);

  state_e           state, state_next;
  logic [WIDTH-1:0] acc [NUM_ACC];
  logic             btnd_lvl, btnd_q, go;
  logic             capture, mul_start, mul_valid;
  logic             wb_en, wb_ovf, alu_ovf;
  logic [WIDTH-1:0] wb_data, alu_res, mul_lo, mul_hi;
  op_e              op_q;
  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] a_q, b_q;

`ifdef CALC_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic            btnd_f;
  logic [DB_W-1:0] db_cnt;

  // Level follows the raw button only after DEBOUNCE_CYCLES differing samples in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnd_f <= 1'b1;
      db_cnt <= '0;
    end else if (btnd == btnd_f) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      btnd_f <= btnd;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
  assign btnd_lvl = btnd_f;
`else
  assign btnd_lvl = btnd;
`endif

  assign go  = btnd_lvl & ~btnd_q;
  assign led = acc[sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (go) state_next = (op_e'(op) == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_next = ST_IDLE;
      ST_MUL:  if (mul_valid) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    capture   = (state == ST_IDLE) && go;
    mul_start = capture && (op_e'(op) == OP_MUL);
    wb_en     = 1'b0;
    wb_data   = alu_res;
    wb_ovf    = alu_ovf;
    unique case (state)
      ST_EXEC: wb_en = 1'b1;
      ST_MUL: begin
        wb_en   = mul_valid;
        wb_data = mul_lo;
        wb_ovf  = |mul_hi;
      end
      default: wb_en = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_res = a_q + b_q;
        alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = a_q - b_q;
        alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLL:  alu_res = a_q << b_q[SH_W-1:0];
      OP_SRL:  alu_res = a_q >> b_q[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      btnd_q <= 1'b1;
      done   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      op_q   <= OP_ADD;
      sel_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      btnd_q <= btnd_lvl;
      done   <= wb_en;
      if (capture) begin
        op_q  <= op_e'(op);
        sel_q <= sel;
        a_q   <= acc[sel];
        b_q   <= sw;
      end
      if (wb_en) begin
        acc[sel_q] <= wb_data;
        zero       <= (wb_data == '0);
        ovf        <= wb_ovf;
      end
    end
  end

  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (acc[sel]),
    .b       (sw),
    .prod_lo (mul_lo),
    .prod_hi (mul_hi),
    .valid   (mul_valid)
  );

endmodule

// File: tb/tb_calc_acc_bank.sv
// Directed self-checking bench for calc_acc_bank (WIDTH=16, NUM_ACC=4, no debounce).
module tb_calc_acc_bank;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btnd;
  logic [2:0]  op;
  logic [1:0]  sel;
  logic [15:0] sw;
  logic [15:0] led;
  logic        busy, done, zero, ovf;

  int checks   = 0;
  int failures = 0;

  calc_acc_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btnd  (btnd),
    .op    (op),
    .sel   (sel),
    .sw    (sw),
    .led   (led),
    .busy  (busy),
    .done  (done),
    .zero  (zero),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Press, release (or re-press mid-flight), wait for done; busy_exp counts busy cycles before done
  task automatic run_op(input string tag, input logic [2:0] o, input logic [1:0] s,
                        input logic [15:0] v, input logic [15:0] exp_led,
                        input logic exp_zero, input logic exp_ovf,
                        input int busy_exp, input bit repress);
    int bc;
    int extra;
    bit seen;
    bc = 0;
    extra = 0;
    seen = 1'b0;
    @(negedge clk);
    op = o; sel = s; sw = v; btnd = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " busy_rise"}, busy, 1);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!repress && i == 0) btnd = 1'b0;
      if (repress && i == 1) btnd = 1'b0;
      if (repress && i == 3) begin
        btnd = 1'b1;
        op = OP_ADD;
        sw = 16'h0002;
      end
      if (done) seen = 1'b1;
      else bc += int'(busy);
    end
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " busy_cycles"}, bc, busy_exp);
    chk({tag, " led"}, led, exp_led);
    chk({tag, " zero"}, zero, exp_zero);
    chk({tag, " ovf"}, ovf, exp_ovf);
    chk({tag, " busy_fall"}, busy, 0);
    @(negedge clk);
    chk({tag, " done_single"}, done, 0);
    btnd = 1'b0;
    if (repress) begin
      repeat (4) begin
        @(negedge clk);
        extra += int'(done);
      end
      chk({tag, " repress_ignored"}, extra, 0);
      chk({tag, " led_after"}, led, exp_led);
    end
  endtask

  initial begin
    int dc;
    int bsum;
    rst_n = 1'b0; btnd = 1'b0; op = 3'd0; sel = 2'd0; sw = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("reset led sel%0d", s), led, 16'h0000);
    end
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset zero", zero, 0);
    chk("reset ovf", ovf, 0);

    run_op("add0",  OP_ADD, 2'd0, 16'h354a, 16'h354a, 1'b0, 1'b0, 1, 1'b0);
    run_op("sub0",  OP_SUB, 2'd0, 16'h354a, 16'h0000, 1'b1, 1'b0, 1, 1'b0);
    run_op("add1a", OP_ADD, 2'd1, 16'h7fff, 16'h7fff, 1'b0, 1'b0, 1, 1'b0);
    run_op("add1b", OP_ADD, 2'd1, 16'h0001, 16'h8000, 1'b0, 1'b1, 1, 1'b0);
    run_op("sub1",  OP_SUB, 2'd1, 16'h0001, 16'h7fff, 1'b0, 1'b1, 1, 1'b0);
    run_op("add3",  OP_ADD, 2'd3, 16'h0001, 16'h0001, 1'b0, 1'b0, 1, 1'b0);
    run_op("sll3",  OP_SLL, 2'd3, 16'h0004, 16'h0010, 1'b0, 1'b0, 1, 1'b0);
    run_op("srl3",  OP_SRL, 2'd3, 16'h0002, 16'h0004, 1'b0, 1'b0, 1, 1'b0);
    run_op("xor3",  OP_XOR, 2'd3, 16'h00ff, 16'h00fb, 1'b0, 1'b0, 1, 1'b0);
    run_op("and3",  OP_AND, 2'd3, 16'h000f, 16'h000b, 1'b0, 1'b0, 1, 1'b0);
    run_op("or3",   OP_OR,  2'd3, 16'h0100, 16'h010b, 1'b0, 1'b0, 1, 1'b0);
    run_op("srl3m", OP_SRL, 2'd3, 16'hfff4, 16'h0010, 1'b0, 1'b0, 1, 1'b0);
    run_op("mul3",  OP_MUL, 2'd3, 16'h0003, 16'h0030, 1'b0, 1'b0, 16, 1'b0);
    run_op("add2",  OP_ADD, 2'd2, 16'h1234, 16'h1234, 1'b0, 1'b0, 1, 1'b0);
    run_op("mul2",  OP_MUL, 2'd2, 16'h0010, 16'h2340, 1'b0, 1'b1, 16, 1'b1);

    sel = 2'd1;
    #1;
    chk("bank sel1 kept", led, 16'h7fff);

    // Held button: one press, one op
    @(negedge clk);
    sel = 2'd0; op = OP_ADD; sw = 16'h0001; btnd = 1'b1;
    dc = 0;
    repeat (10) begin
      @(negedge clk);
      dc += int'(done);
    end
    btnd = 1'b0;
    repeat (4) begin
      @(negedge clk);
      dc += int'(done);
    end
    chk("held done count", dc, 1);
    chk("held led", led, 16'h0001);

    // Reset mid-multiply with button held across release
    @(negedge clk);
    sel = 2'd2; op = OP_MUL; sw = 16'h0003; btnd = 1'b1;
    repeat (5) @(negedge clk);
    chk("midmul busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midmul rst busy", busy, 0);
    chk("midmul rst led", led, 16'h0000);
    chk("midmul rst done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    bsum = 0;
    repeat (6) begin
      @(negedge clk);
      dc += int'(done);
      bsum += int'(busy);
    end
    chk("held release done", dc, 0);
    chk("held release busy", bsum, 0);
    chk("held release led", led, 16'h0000);
    sel = 2'd1;
    #1;
    chk("reset cleared sel1", led, 16'h0000);
    btnd = 1'b0;
    @(negedge clk);
    run_op("post_rst", OP_ADD, 2'd2, 16'h0005, 16'h0005, 1'b0, 1'b0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
